mem_stage: RTL

- MEM pipeline stage, between EX and WB.
- Takes ALU result, store data and control from EX.
- Runs load/store transactions on a req/gnt/rvalid data-memory port.
- Registers retired instructions into the MEM/WB interface consumed by WB: alu_result, mem_data, dest_reg, reg_we, wdata_mux.
- Stalls EX via ready_o while a memory access is outstanding.

---
 rtl/mem_stage.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage: MEM pipeline stage between EX and WB.
//
// Accepts one instruction per cycle from EX (valid_i/ready_o handshake). ALU-only
// instructions pass straight into the MEM/WB register with one cycle of latency.
// Loads and stores are issued on a req/gnt/rvalid data-memory port. EX is stalled
// (ready_o low) until the access retires.
//
// Optional build macro:
//   MEM_MISALIGN_TRAP_EN - adds misalign_o. Misaligned half/word accesses then
//                          issue no memory request. They retire one cycle after
//                          acceptance with wb_reg_we_o=0, and misalign_o pulses
//                          alongside wb_valid_o. Without the macro the offending
//                          low address bits are ignored.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   valid_i / ready_o      EX handshake; ready_o is high only while idle
//   alu_result_i           ALU result, or effective address for memory ops
//   store_data_i           rs2 data for stores
//   dest_reg_i, reg_we_i   register-file destination and write enable
//   mem_read_i/mem_write_i load / store (mutually exclusive)
//   mem_size_i             00 byte, 01 half, 10/11 word
//   mem_unsigned_i         zero-extend loaded data
//   data_*                 data-memory port (word-aligned address, byte enables,
//                          lane-replicated write data)
//   wb_*                   MEM/WB register outputs consumed by WB
//   misalign_o             (MEM_MISALIGN_TRAP_EN only) misaligned access retired
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    // EX -> MEM
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [ADDR_WIDTH-1:0] dest_reg_i,
    input  logic                  reg_we_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,

    // Data-memory port
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,

    // MEM/WB register
    output logic                  wb_valid_o,
    output logic [DATA_WIDTH-1:0] wb_alu_result_o,
    output logic [DATA_WIDTH-1:0] wb_mem_data_o,
    output logic [ADDR_WIDTH-1:0] wb_dest_reg_o,
    output logic                  wb_reg_we_o,
    output logic                  wb_wdata_mux_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRvalid
    } state_e;

    state_e state_q, state_d;

    // Captured memory operation; held stable for the whole transaction.
    logic [DATA_WIDTH-1:0] op_addr_q,     op_addr_d;
    logic [DATA_WIDTH-1:0] op_wdata_q,    op_wdata_d;
    logic [3:0]            op_be_q,       op_be_d;
    logic                  op_we_q,       op_we_d;
    logic [1:0]            op_size_q,     op_size_d;
    logic                  op_unsigned_q, op_unsigned_d;
    logic [ADDR_WIDTH-1:0] op_dest_q,     op_dest_d;
    logic                  op_reg_we_q,   op_reg_we_d;

    // MEM/WB register
    logic                  wb_valid_q,    wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_alu_q,      wb_alu_d;
    logic [DATA_WIDTH-1:0] wb_mem_data_q, wb_mem_data_d;
    logic [ADDR_WIDTH-1:0] wb_dest_q,     wb_dest_d;
    logic                  wb_reg_we_q,   wb_reg_we_d;
    logic                  wb_mux_q,      wb_mux_d;

    logic                  mem_op;
    logic                  trap;
    logic [3:0]            acc_be;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [4:0]            ld_shift;
    logic [DATA_WIDTH-1:0] ld_shifted;
    logic [DATA_WIDTH-1:0] ld_data;

    assign mem_op = mem_read_i | mem_write_i;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q, misalign_d;

    // Size 11 counts as word, hence the test on mem_size_i[1] alone.
    assign misaligned = ((mem_size_i == 2'b01) && alu_result_i[0]) ||
                        (mem_size_i[1] && (alu_result_i[1:0] != 2'b00));
    assign trap       = mem_op & misaligned;
    assign misalign_o = misalign_q;
`else
    assign trap = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the incoming instruction.
    // Half/word ignore the address bits below their natural alignment.
    always_comb begin
        acc_be    = 4'b1111;
        acc_wdata = store_data_i;
        case (mem_size_i)
            2'b00: begin
                acc_be    = 4'b0001 << alu_result_i[1:0];
                acc_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                acc_be    = 4'b0011 << {alu_result_i[1], 1'b0};
                acc_wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                acc_be    = 4'b1111;
                acc_wdata = store_data_i;
            end
        endcase
    end

    // Load data: move the addressed lane down to bit 0, then extend.
    always_comb begin
        ld_shift = 5'd0;
        case (op_size_q)
            2'b00:   ld_shift = {op_addr_q[1:0], 3'b000};
            2'b01:   ld_shift = {op_addr_q[1], 4'b0000};
            default: ld_shift = 5'd0;
        endcase
    end

    assign ld_shifted = data_rdata_i >> ld_shift;

    always_comb begin
        ld_data = ld_shifted;
        case (op_size_q)
            2'b00: ld_data = op_unsigned_q ? {24'b0, ld_shifted[7:0]}
                                           : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01: ld_data = op_unsigned_q ? {16'b0, ld_shifted[15:0]}
                                           : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    // Next-state logic. wb_valid/wb_reg_we default low so they only pulse on retire;
    // the other MEM/WB fields hold their last values.
    always_comb begin
        state_d       = state_q;
        op_addr_d     = op_addr_q;
        op_wdata_d    = op_wdata_q;
        op_be_d       = op_be_q;
        op_we_d       = op_we_q;
        op_size_d     = op_size_q;
        op_unsigned_d = op_unsigned_q;
        op_dest_d     = op_dest_q;
        op_reg_we_d   = op_reg_we_q;
        wb_valid_d    = 1'b0;
        wb_reg_we_d   = 1'b0;
        wb_alu_d      = wb_alu_q;
        wb_mem_data_d = wb_mem_data_q;
        wb_dest_d     = wb_dest_q;
        wb_mux_d      = wb_mux_q;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d    = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                if (valid_i) begin
                    if (!mem_op || trap) begin
                        // ALU op, or a trapped misaligned access: retire next edge.
                        wb_valid_d  = 1'b1;
                        wb_reg_we_d = reg_we_i & ~trap;
                        wb_alu_d    = alu_result_i;
                        wb_dest_d   = dest_reg_i;
                        wb_mux_d    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_d  = trap;
`endif
                    end else begin
                        state_d       = StReq;
                        op_addr_d     = alu_result_i;
                        op_wdata_d    = acc_wdata;
                        op_be_d       = acc_be;
                        op_we_d       = mem_write_i;
                        op_size_d     = mem_size_i;
                        op_unsigned_d = mem_unsigned_i;
                        op_dest_d     = dest_reg_i;
                        op_reg_we_d   = reg_we_i;
                    end
                end
            end

            StReq: begin
                if (data_gnt_i) begin
                    if (op_we_q) begin
                        // Stores complete on grant; there is no response to wait for.
                        state_d     = StIdle;
                        wb_valid_d  = 1'b1;
                        wb_reg_we_d = 1'b0;
                        wb_alu_d    = op_addr_q;
                        wb_dest_d   = op_dest_q;
                        wb_mux_d    = 1'b0;
                    end else begin
                        state_d = StWaitRvalid;
                    end
                end
            end

            StWaitRvalid: begin
                if (data_rvalid_i) begin
                    state_d       = StIdle;
                    wb_valid_d    = 1'b1;
                    wb_reg_we_d   = op_reg_we_q;
                    wb_alu_d      = op_addr_q;
                    wb_mem_data_d = ld_data;
                    wb_dest_d     = op_dest_q;
                    wb_mux_d      = 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            op_addr_q     <= '0;
            op_wdata_q    <= '0;
            op_be_q       <= '0;
            op_we_q       <= 1'b0;
            op_size_q     <= '0;
            op_unsigned_q <= 1'b0;
            op_dest_q     <= '0;
            op_reg_we_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_alu_q      <= '0;
            wb_mem_data_q <= '0;
            wb_dest_q     <= '0;
            wb_reg_we_q   <= 1'b0;
            wb_mux_q      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            op_addr_q     <= op_addr_d;
            op_wdata_q    <= op_wdata_d;
            op_be_q       <= op_be_d;
            op_we_q       <= op_we_d;
            op_size_q     <= op_size_d;
            op_unsigned_q <= op_unsigned_d;
            op_dest_q     <= op_dest_d;
            op_reg_we_q   <= op_reg_we_d;
            wb_valid_q    <= wb_valid_d;
            wb_alu_q      <= wb_alu_d;
            wb_mem_data_q <= wb_mem_data_d;
            wb_dest_q     <= wb_dest_d;
            wb_reg_we_q   <= wb_reg_we_d;
            wb_mux_q      <= wb_mux_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    // Request and port fields come straight from registers, so they are glitch-free
    // and stable from the cycle after acceptance until grant.
    assign ready_o      = (state_q == StIdle);
    assign data_req_o   = (state_q == StReq);
    assign data_addr_o  = {op_addr_q[DATA_WIDTH-1:2], 2'b00};
    assign data_we_o    = op_we_q;
    assign data_be_o    = op_be_q;
    assign data_wdata_o = op_wdata_q;

    assign wb_valid_o      = wb_valid_q;
    assign wb_alu_result_o = wb_alu_q;
    assign wb_mem_data_o   = wb_mem_data_q;
    assign wb_dest_reg_o   = wb_dest_q;
    assign wb_reg_we_o     = wb_reg_we_q;
    assign wb_wdata_mux_o  = wb_mux_q;

endmodule
